rr_onehot_sel: RTL and testbench

Round-robin select generator that sits directly upstream of the one-hot 4:1 select mux and drives its `sel` input. It arbitrates among four request lines, issues a registered one-hot grant that is held stable while the owner is served, and rotates priority fairly. A hold-time limit forces rotation if an owner never releases. Every `sel_o` value is either all-zero or exactly one-hot, so the mux never sees a multi-hot select.

---
 rtl/rr_onehot_sel.sv | 84 ++++++++
 tb/tb_rr_onehot_sel.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_sel.sv
// Round-robin arbiter that drives the sel input of the one-hot 4:1 mux.
// A grant is held until release, owner withdrawal, or a HOLD_MAX timeout.
`timescale 1ns/1ps
module rr_onehot_sel #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req_i,
  input  logic       release_i,
  output logic [3:0] sel_o,
  output logic [1:0] owner_o,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [1:0]    last;
  logic [CW-1:0] hold_cnt;
  logic [1:0]    winner;
  logic          found;
  logic          exit_rel;
  logic          exit_tmo;

  // Priority search starts just after the previous owner and wraps; k=4 lands back on last.
  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && req_i[last + 2'(k)]) begin
        winner = last + 2'(k);
        found  = 1'b1;
      end
    end
  end

  assign exit_rel = release_i || !req_i[owner_o];
  assign exit_tmo = (hold_cnt == HOLD_LAST);

  // Leaving GRANT always passes through IDLE, so sel_o never jumps between two one-hot values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      last      <= 2'd3;
      hold_cnt  <= '0;
      sel_o     <= 4'b0000;
      owner_o   <= 2'd0;
      busy_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_i) begin
            state    <= GRANT;
            sel_o    <= 4'b0001 << winner;
            owner_o  <= winner;
            busy_o   <= 1'b1;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (exit_rel || exit_tmo) begin
            state     <= IDLE;
            last      <= owner_o;
            sel_o     <= 4'b0000;
            owner_o   <= 2'd0;
            busy_o    <= 1'b0;
            timeout_o <= exit_tmo && !exit_rel;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_onehot_sel.sv
// Directed bench for rr_onehot_sel: vector table on a HOLD_MAX=4 instance,
// plus hand-written async-reset and HOLD_MAX=1 sequences.
`timescale 1ns/1ps
module tb_rr_onehot_sel;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       rel = 1'b0;

  logic [3:0] sel, sel1;
  logic [1:0] owner, owner1;
  logic       busy, busy1;
  logic       tmo, tmo1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rel;
    logic [3:0] sel;
    logic [1:0] owner;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  rr_onehot_sel #(.HOLD_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n), .req_i(req), .release_i(rel),
    .sel_o(sel), .owner_o(owner), .busy_o(busy), .timeout_o(tmo)
  );

  rr_onehot_sel #(.HOLD_MAX(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req_i(req), .release_i(rel),
    .sel_o(sel1), .owner_o(owner1), .busy_o(busy1), .timeout_o(tmo1)
  );

  function automatic vec_t mkv(logic r, logic [3:0] q, logic l,
                               logic [3:0] s, logic [1:0] o, logic t);
    vec_t v;
    v.rst_n = r; v.req = q; v.rel = l; v.sel = s; v.owner = o; v.tmo = t;
    return v;
  endfunction

  // Packed as {sel, owner, busy, timeout}; busy is derived from the expected sel.
  function automatic logic [7:0] pack_exp(logic [3:0] s, logic [1:0] o, logic t);
    return {s, o, |s, t};
  endfunction

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got sel=%b owner=%0d busy=%b tmo=%b, want sel=%b owner=%0d busy=%b tmo=%b",
               name, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    @(negedge clk);
    reset_n = v.rst_n;
    req     = v.req;
    rel     = v.rel;
    @(posedge clk);
    #1;
    check_output($sformatf("vec%0d", idx), {sel, owner, busy, tmo},
                 pack_exp(v.sel, v.owner, v.tmo));
  endtask

  initial begin
    // Single request, release in the third grant cycle
    vecs.push_back(mkv(1, 4'b0100, 0, 4'b0100, 2, 0));
    vecs.push_back(mkv(1, 4'b0100, 0, 4'b0100, 2, 0));
    vecs.push_back(mkv(1, 4'b0100, 0, 4'b0100, 2, 0));
    vecs.push_back(mkv(1, 4'b0100, 1, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 4'b0000, 0, 4'b0000, 0, 0));
    // Reset, then fair rotation with release on every grant
    vecs.push_back(mkv(0, 4'b1111, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 4'b1111, 0, 4'b0001, 0, 0));
    vecs.push_back(mkv(1, 4'b1111, 1, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 4'b1111, 0, 4'b0010, 1, 0));
    vecs.push_back(mkv(1, 4'b1111, 1, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 4'b1111, 0, 4'b0100, 2, 0));
    vecs.push_back(mkv(1, 4'b1111, 1, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 4'b1111, 0, 4'b1000, 3, 0));
    vecs.push_back(mkv(1, 4'b1111, 1, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 4'b1111, 0, 4'b0001, 0, 0));
    vecs.push_back(mkv(1, 4'b1111, 1, 4'b0000, 0, 0));
    // Timeout after 4 held cycles, then re-grant
    vecs.push_back(mkv(1, 4'b0010, 0, 4'b0010, 1, 0));
    vecs.push_back(mkv(1, 4'b0010, 0, 4'b0010, 1, 0));
    vecs.push_back(mkv(1, 4'b0010, 0, 4'b0010, 1, 0));
    vecs.push_back(mkv(1, 4'b0010, 0, 4'b0010, 1, 0));
    vecs.push_back(mkv(1, 4'b0010, 0, 4'b0000, 0, 1));
    vecs.push_back(mkv(1, 4'b0010, 0, 4'b0010, 1, 0));
    vecs.push_back(mkv(1, 4'b0010, 0, 4'b0010, 1, 0));
    vecs.push_back(mkv(1, 4'b0010, 0, 4'b0010, 1, 0));
    vecs.push_back(mkv(1, 4'b0010, 0, 4'b0010, 1, 0));
    // Release in the 4th grant cycle: a normal release, no timeout pulse
    vecs.push_back(mkv(1, 4'b0010, 1, 4'b0000, 0, 0));
    // Make requester 0 the last owner via withdrawal
    vecs.push_back(mkv(1, 4'b0001, 0, 4'b0001, 0, 0));
    vecs.push_back(mkv(1, 4'b0000, 0, 4'b0000, 0, 0));
    // last=0, req=1001 -> owner 3; request changes mid-grant ignored
    vecs.push_back(mkv(1, 4'b1001, 0, 4'b1000, 3, 0));
    vecs.push_back(mkv(1, 4'b1111, 0, 4'b1000, 3, 0));
    vecs.push_back(mkv(1, 4'b0001, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 4'b0001, 0, 4'b0001, 0, 0));
    vecs.push_back(mkv(1, 4'b0001, 1, 4'b0000, 0, 0));

    // Power-on reset, checked before any clock edge
    #2 reset_n = 1'b0;
    #1;
    check_output("reset_state", {sel, owner, busy, tmo}, pack_exp(4'b0000, 0, 0));
    check_output("reset_state_h1", {sel1, owner1, busy1, tmo1}, pack_exp(4'b0000, 0, 0));
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);

    // Asynchronous reset in the middle of a grant
    @(negedge clk);
    reset_n = 1'b1; req = 4'b0100; rel = 1'b0;
    @(posedge clk); #1;
    check_output("pre_reset_grant", {sel, owner, busy, tmo}, pack_exp(4'b0100, 2, 0));
    #2 reset_n = 1'b0;
    #1;
    check_output("async_reset", {sel, owner, busy, tmo}, pack_exp(4'b0000, 0, 0));
    @(negedge clk);
    reset_n = 1'b1; req = 4'b1111;
    @(posedge clk); #1;
    check_output("post_reset_grant", {sel, owner, busy, tmo}, pack_exp(4'b0001, 0, 0));

    // HOLD_MAX=1: one-cycle grants with timeout pulses in between
    @(negedge clk);
    reset_n = 1'b0; req = 4'b0100; rel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_output("h1_grant0", {sel1, owner1, busy1, tmo1}, pack_exp(4'b0100, 2, 0));
    @(posedge clk); #1;
    check_output("h1_timeout", {sel1, owner1, busy1, tmo1}, pack_exp(4'b0000, 0, 1));
    @(posedge clk); #1;
    check_output("h1_grant1", {sel1, owner1, busy1, tmo1}, pack_exp(4'b0100, 2, 0));
    @(negedge clk);
    rel = 1'b1;
    @(posedge clk); #1;
    check_output("h1_release", {sel1, owner1, busy1, tmo1}, pack_exp(4'b0000, 0, 0));
    @(negedge clk);
    rel = 1'b0; req = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
